// File: rtl/stream_traffic_sequencer_if.sv
// Command-channel bundle for stream_traffic_sequencer: one write and one read
// valid/ready command channel, each carrying address, 1-based beat length and stream id.
interface stream_traffic_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              wr_cmd_valid;
    logic              wr_cmd_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [6:0]        wr_len;
    logic [7:0]        wr_stream;

    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [6:0]        rd_len;
    logic [7:0]        rd_stream;

    modport master (
        output wr_cmd_valid, wr_addr, wr_len, wr_stream,
        input  wr_cmd_ready,
        output rd_cmd_valid, rd_addr, rd_len, rd_stream,
        input  rd_cmd_ready
    );

    modport slave (
        input  wr_cmd_valid, wr_addr, wr_len, wr_stream,
        output wr_cmd_ready,
        input  rd_cmd_valid, rd_addr, rd_len, rd_stream,
        output rd_cmd_ready
    );
endinterface

// File: rtl/stream_traffic_sequencer.sv
// Sweeps per-stream address regions with write bursts, then cycles read bursts once a full
// write pass is done. Define TRAFFIC_RAND_EN for LFSR-chosen streams/write lengths after pass 0.
module stream_traffic_sequencer #(
    parameter int unsigned N_STREAMS    = 144,
    parameter int unsigned N_RD_STREAMS = 12,
    parameter int unsigned STREAM_BEATS = 3600,
    parameter int unsigned WR_BURST_MAX = 8,
    parameter int unsigned RD_BURST_MAX = 20,
    parameter int unsigned STREAM_SHIFT = 20,
    parameter int unsigned N_ITER       = 0,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    stream_traffic_sequencer_if.master  cmd,
    output logic [7:0]                  iter_num,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {W_IDLE, W_BURST, W_NEXT, W_DONE} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_BURST, R_NEXT} rd_state_e;

    localparam logic [16:0] BEATS   = 17'(STREAM_BEATS);
    localparam logic [7:0]  LAST_WR = 8'(N_STREAMS - 1);
    localparam logic [7:0]  LAST_RD = 8'(N_RD_STREAMS - 1);
    localparam logic [6:0]  RD_DES  = 7'(RD_BURST_MAX);

    // Clamp so a burst never crosses a 64-beat (4 KB) page or the end of the stream.
    function automatic logic [6:0] burst_len(input logic [15:0] beat, input logic [6:0] desired);
        logic [16:0] rem_stream;
        logic [6:0]  rem_page;
        logic [6:0]  len;
        rem_stream = BEATS - {1'b0, beat};
        rem_page   = 7'd64 - {1'b0, beat[5:0]};
        len        = desired;
        if (rem_page < len) len = rem_page;
        if (rem_stream < {10'd0, len}) len = rem_stream[6:0];
        return len;
    endfunction

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] stream, input logic [15:0] beat);
        return (ADDR_W'(stream) << STREAM_SHIFT) | (ADDR_W'(beat) << 6);
    endfunction

    wr_state_e         wr_state_q, wr_state_d;
    logic [15:0]       wr_beat_q, wr_beat_d;
    logic [7:0]        wr_stream_q, wr_stream_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [6:0]        wr_len_q, wr_len_d;
    logic [7:0]        iter_q, iter_d;

    rd_state_e         rd_state_q, rd_state_d;
    logic [15:0]       rd_beat_q, rd_beat_d;
    logic [7:0]        rd_stream_q, rd_stream_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [6:0]        rd_len_q, rd_len_d;
    logic              rd_ran_q, rd_ran_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [16:0]       wr_sum, rd_sum;
    logic              wr_last, rd_last;
    logic [7:0]        iter_inc, wr_seq, wr_next, rd_seq;
    logic [6:0]        wr_des;

`ifdef TRAFFIC_RAND_EN
    logic [31:0]       lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : '0);
    end
`endif

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_beat_d   = wr_beat_q;
        wr_stream_d = wr_stream_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_len_d    = wr_len_q;
        iter_d      = iter_q;

        wr_sum   = {1'b0, wr_beat_q} + {10'd0, wr_len_q};
        wr_last  = (wr_stream_q == LAST_WR);
        iter_inc = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
        wr_seq   = wr_last ? '0 : wr_stream_q + 8'd1;
`ifdef TRAFFIC_RAND_EN
        wr_des   = (lfsr_q[6:0] & 7'(WR_BURST_MAX - 1)) + 7'd1;
        // Stream order turns random once the iteration being started is >= 1.
        wr_next  = ((wr_last ? iter_inc : iter_q) != 8'd0)
                   ? 8'(lfsr_q[15:0] % 16'(N_STREAMS)) : wr_seq;
`else
        wr_des   = 7'(WR_BURST_MAX);
        wr_next  = wr_seq;
`endif

        case (wr_state_q)
            W_IDLE: begin
                if (en) begin
                    wr_state_d  = W_BURST;
                    wr_beat_d   = '0;
                    wr_stream_d = '0;
                    wr_valid_d  = 1'b1;
                    wr_addr_d   = cmd_addr(8'd0, 16'd0);
                    wr_len_d    = burst_len(16'd0, wr_des);
                end
            end
            W_BURST: begin
                if (wr_valid_q && cmd.wr_cmd_ready) begin
                    wr_beat_d = wr_sum[15:0];
                    if (wr_sum == BEATS) begin
                        wr_state_d = W_NEXT;
                        wr_valid_d = 1'b0;
                    end else begin
                        wr_addr_d = cmd_addr(wr_stream_q, wr_sum[15:0]);
                        wr_len_d  = burst_len(wr_sum[15:0], wr_des);
                    end
                end
            end
            W_NEXT: begin
                wr_beat_d = '0;
                if (wr_last) iter_d = iter_inc;
                if (wr_last && (N_ITER != 0) && (32'(iter_inc) == N_ITER)) begin
                    wr_state_d = W_DONE;
                end else begin
                    wr_state_d  = W_BURST;
                    wr_stream_d = wr_next;
                    wr_valid_d  = 1'b1;
                    wr_addr_d   = cmd_addr(wr_next, 16'd0);
                    wr_len_d    = burst_len(16'd0, wr_des);
                end
            end
            W_DONE: begin
                wr_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_beat_d   = rd_beat_q;
        rd_stream_d = rd_stream_q;
        rd_valid_d  = rd_valid_q;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        rd_ran_d    = rd_ran_q;

        rd_sum  = {1'b0, rd_beat_q} + {10'd0, rd_len_q};
        rd_last = (rd_stream_q == LAST_RD);
        rd_seq  = rd_last ? '0 : rd_stream_q + 8'd1;

        case (rd_state_q)
            R_IDLE: begin
                // Starts only once, after the first complete write pass.
                if (!rd_ran_q && (iter_q != 8'd0)) begin
                    rd_state_d  = R_BURST;
                    rd_ran_d    = 1'b1;
                    rd_beat_d   = '0;
                    rd_stream_d = '0;
                    rd_valid_d  = 1'b1;
                    rd_addr_d   = cmd_addr(8'd0, 16'd0);
                    rd_len_d    = burst_len(16'd0, RD_DES);
                end
            end
            R_BURST: begin
                if (rd_valid_q && cmd.rd_cmd_ready) begin
                    rd_beat_d = rd_sum[15:0];
                    if (rd_sum == BEATS) begin
                        rd_state_d = R_NEXT;
                        rd_valid_d = 1'b0;
                    end else begin
                        rd_addr_d = cmd_addr(rd_stream_q, rd_sum[15:0]);
                        rd_len_d  = burst_len(rd_sum[15:0], RD_DES);
                    end
                end
            end
            R_NEXT: begin
                rd_beat_d = '0;
                if ((wr_state_q == W_DONE) && rd_last) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d  = R_BURST;
                    rd_stream_d = rd_seq;
                    rd_valid_d  = 1'b1;
                    rd_addr_d   = cmd_addr(rd_seq, 16'd0);
                    rd_len_d    = burst_len(16'd0, RD_DES);
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // Status is derived from next-state so the registered flags line up with the FSM registers.
    always_comb begin
        busy_d = (wr_state_d == W_BURST) || (wr_state_d == W_NEXT) || (rd_state_d != R_IDLE);
        done_d = (wr_state_d == W_DONE) && (rd_state_d == R_IDLE) && rd_ran_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q  <= W_IDLE;
            wr_beat_q   <= '0;
            wr_stream_q <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_len_q    <= '0;
            iter_q      <= '0;
            rd_state_q  <= R_IDLE;
            rd_beat_q   <= '0;
            rd_stream_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
            rd_ran_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef TRAFFIC_RAND_EN
            lfsr_q      <= 32'hACE1_ACE1;
`endif
        end else begin
            wr_state_q  <= wr_state_d;
            wr_beat_q   <= wr_beat_d;
            wr_stream_q <= wr_stream_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_len_q    <= wr_len_d;
            iter_q      <= iter_d;
            rd_state_q  <= rd_state_d;
            rd_beat_q   <= rd_beat_d;
            rd_stream_q <= rd_stream_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            rd_ran_q    <= rd_ran_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef TRAFFIC_RAND_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign cmd.wr_cmd_valid = wr_valid_q;
    assign cmd.wr_addr      = wr_addr_q;
    assign cmd.wr_len       = wr_len_q;
    assign cmd.wr_stream    = wr_stream_q;
    assign cmd.rd_cmd_valid = rd_valid_q;
    assign cmd.rd_addr      = rd_addr_q;
    assign cmd.rd_len       = rd_len_q;
    assign cmd.rd_stream    = rd_stream_q;
    assign iter_num         = iter_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
